// File: rtl/alu_result_fifo.sv
// Result FIFO between an ALU and its consumer: stores each result with its op tag,
// flags undefined ops and counts producer stall cycles.
module alu_result_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESET,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         c,
    input  logic [1:0]               op,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    output logic [1:0]               out_op,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     bad_op,
    input  logic                     clr_err,
    output logic [7:0]               stall_cnt
);

    localparam int             AW         = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_COUNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        OP_ADD   = 2'd0,
        OP_SUB   = 2'd1,
        OP_MUL   = 2'd2,
        OP_UNDEF = 2'd3
    } op_e;

    logic [WIDTH-1:0] data_mem [DEPTH];
    op_e              op_mem   [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push;
    logic             pop;
    logic             stall;

    // Handshake is derived from registered occupancy only, so in_ready never
    // depends on out_ready in the same cycle.
    always_comb begin
        in_ready  = (count < FULL_COUNT);
        out_valid = (count != '0);
        push      = in_valid & in_ready;
        pop       = out_valid & out_ready;
        stall     = in_valid & ~in_ready;
        out_data  = data_mem[rd_ptr];
        out_op    = op_mem[rd_ptr];
    end

    // NOTE: storage is reset too, so out_data/out_op read 0 rather than X
    // after reset even though the head is not valid.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_mem[i] <= '0;
                op_mem[i]   <= OP_ADD;
            end
        end else if (push) begin
            data_mem[wr_ptr] <= c;
            op_mem[wr_ptr]   <= op_e'(op);
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge value of its neighbours.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // A new undefined-op entry outranks a concurrent clear.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            bad_op <= 1'b0;
        end else if (push && (op_e'(op) == OP_UNDEF)) begin
            bad_op <= 1'b1;
        end else if (clr_err) begin
            bad_op <= 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            stall_cnt <= '0;
        end else if (stall && (stall_cnt != 8'hFF)) begin
            stall_cnt <= stall_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_alu_result_fifo.sv
// Self-checking bench for alu_result_fifo: queue-based reference model compared
// every cycle, plus directed vectors with hand-computed literal expectations.
module tb_alu_result_fifo;

    localparam int DEPTH = 4;
    localparam int WIDTH = 16;

    logic              CLK        = 1'b0;
    logic              ASYNCRESET = 1'b1;
    logic              in_valid   = 1'b0;
    logic [WIDTH-1:0]  c          = '0;
    logic [1:0]        op         = '0;
    logic              out_ready  = 1'b0;
    logic              clr_err    = 1'b0;
    logic              in_ready;
    logic              out_valid;
    logic [WIDTH-1:0]  out_data;
    logic [1:0]        out_op;
    logic [2:0]        count;
    logic              bad_op;
    logic [7:0]        stall_cnt;

    alu_result_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .CLK        (CLK),
        .ASYNCRESET (ASYNCRESET),
        .in_valid   (in_valid),
        .c          (c),
        .op         (op),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_op     (out_op),
        .out_ready  (out_ready),
        .count      (count),
        .bad_op     (bad_op),
        .clr_err    (clr_err),
        .stall_cnt  (stall_cnt)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain FIFO queue plus the flag/counter rules.
    logic [WIDTH-1:0] m_data [$];
    logic [1:0]       m_op   [$];
    logic             m_bad   = 1'b0;
    int               m_stall = 0;
    bit               m_fresh = 1'b1;

    always @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            m_data.delete();
            m_op.delete();
            m_bad   = 1'b0;
            m_stall = 0;
            m_fresh = 1'b1;
        end else begin
            bit acc;
            bit take;
            acc  = in_valid && (m_data.size() < DEPTH);
            take = out_ready && (m_data.size() > 0);
            if (in_valid && !acc && m_stall < 255) m_stall++;
            if (acc && op == 2'd3) m_bad = 1'b1;
            else if (clr_err)      m_bad = 1'b0;
            if (take) begin
                void'(m_data.pop_front());
                void'(m_op.pop_front());
            end
            if (acc) begin
                m_data.push_back(c);
                m_op.push_back(op);
                m_fresh = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        check("count",     32'(count),     32'(m_data.size()));
        check("in_ready",  32'(in_ready),  32'(m_data.size() < DEPTH));
        check("out_valid", 32'(out_valid), 32'(m_data.size() != 0));
        check("bad_op",    32'(bad_op),    32'(m_bad));
        check("stall_cnt", 32'(stall_cnt), 32'(m_stall));
        if (m_data.size() > 0) begin
            check("out_data", 32'(out_data), 32'(m_data[0]));
            check("out_op",   32'(out_op),   32'(m_op[0]));
        end else if (m_fresh) begin
            check("out_data_rst", 32'(out_data), 32'h0);
            check("out_op_rst",   32'(out_op),   32'h0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [1:0] o, input logic r);
        in_valid  = v;
        c         = d;
        op        = o;
        out_ready = r;
    endtask

    logic [WIDTH-1:0] fill_data [4];
    logic [1:0]       fill_op   [4];

    initial begin
        fill_data = '{16'h0003, 16'hFFFF, 16'h0010, 16'h1234};
        fill_op   = '{2'd0, 2'd1, 2'd2, 2'd0};

        // Reset state
        step();
        step();
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'h0);
        check("rst_out_op",    32'(out_op),    32'h0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_bad_op",    32'(bad_op),    32'd0);
        check("rst_stall",     32'(stall_cnt), 32'd0);
        ASYNCRESET = 1'b0;

        // Fill then drain
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, fill_data[i], fill_op[i], 1'b0);
            step();
        end
        drive(1'b0, '0, 2'd0, 1'b0);
        check("fill_count",    32'(count),    32'd4);
        check("fill_in_ready", 32'(in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 2'd0, 1'b1);
            check("drain_valid", 32'(out_valid), 32'd1);
            check("drain_data",  32'(out_data),  32'(fill_data[i]));
            check("drain_op",    32'(out_op),    32'(fill_op[i]));
            step();
        end
        drive(1'b0, '0, 2'd0, 1'b0);
        check("drain_count", 32'(count),     32'd0);
        check("drain_empty", 32'(out_valid), 32'd0);

        // Simultaneous push/pop at count=2
        drive(1'b1, 16'h0100, 2'd0, 1'b0); step();
        drive(1'b1, 16'h0101, 2'd2, 1'b0); step();
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h0102 + 16'(i), 2'd1, 1'b1);
            check("pp_count", 32'(count),    32'd2);
            check("pp_data",  32'(out_data), 32'h0100 + 32'(i));
            step();
        end
        check("pp_count_end", 32'(count), 32'd2);
        for (int i = 0; i < 2; i++) begin
            drive(1'b0, '0, 2'd0, 1'b1);
            check("pp_tail", 32'(out_data), 32'h010A + 32'(i));
            step();
        end
        drive(1'b0, '0, 2'd0, 1'b0);

        // Error flag set / clear priority
        drive(1'b1, 16'h0000, 2'd3, 1'b0); step();
        drive(1'b0, '0, 2'd0, 1'b0);
        check("err_set", 32'(bad_op), 32'd1);
        drive(1'b1, 16'h0055, 2'd3, 1'b0); clr_err = 1'b1; step();
        drive(1'b0, '0, 2'd0, 1'b0);       clr_err = 1'b1; 
        check("err_set_wins", 32'(bad_op), 32'd1);
        step();
        clr_err = 1'b0;
        check("err_clr", 32'(bad_op), 32'd0);
        drive(1'b0, '0, 2'd0, 1'b1);
        check("err_head0_data", 32'(out_data), 32'h0000);
        check("err_head0_op",   32'(out_op),   32'd3);
        step();
        check("err_head1_data", 32'(out_data), 32'h0055);
        check("err_head1_op",   32'(out_op),   32'd3);
        step();
        drive(1'b0, '0, 2'd0, 1'b0);
        check("err_count", 32'(count), 32'd0);

        // Full stall with saturation
        check("stall_pre", 32'(stall_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 16'hA000 + 16'(i), 2'(i % 3), 1'b0);
            step();
        end
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'hD000 + 16'(i), 2'd1, 1'b0);
            step();
        end
        drive(1'b0, '0, 2'd0, 1'b0);
        check("stall_sat",   32'(stall_cnt), 32'd255);
        check("stall_count", 32'(count),     32'd4);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, '0, 2'd0, 1'b1);
            check("stall_keep", 32'(out_data), 32'hA000 + 32'(i));
            step();
        end
        drive(1'b0, '0, 2'd0, 1'b0);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 16'h0B00 + 16'(i), 2'd2, 1'b0);
            step();
        end
        drive(1'b0, '0, 2'd0, 1'b0);
        check("mid_count", 32'(count), 32'd3);
        #2;
        ASYNCRESET = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_count", 32'(count),     32'd0);
        check("mid_rst_stall", 32'(stall_cnt), 32'd0);
        check("mid_rst_data",  32'(out_data),  32'h0);
        step();
        ASYNCRESET = 1'b0;
        drive(1'b1, 16'h00AA, 2'd1, 1'b0); step();
        drive(1'b0, '0, 2'd0, 1'b0);
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_data",  32'(out_data),  32'h00AA);
        check("post_rst_count", 32'(count),     32'd1);
        drive(1'b0, '0, 2'd0, 1'b1); step();
        drive(1'b0, '0, 2'd0, 1'b0);
        check("post_rst_empty", 32'(count), 32'd0);

        // Pointer wrap: nine single-entry round trips
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 16'h0C00 + 16'(i), 2'(i % 3), 1'b0);
            step();
            drive(1'b0, '0, 2'd0, 1'b1);
            check("wrap_data", 32'(out_data), 32'h0C00 + 32'(i));
            check("wrap_op",   32'(out_op),   32'(i % 3));
            step();
        end
        drive(1'b0, '0, 2'd0, 1'b0);
        check("wrap_count", 32'(count), 32'd0);

        step();
        step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
